// File: rtl/divider_pkg.sv
// Shared definitions for the pipelined restoring divider.
`ifndef max_num_K
`define max_num_K 8
`endif

package divider_pkg;

    // Default geometry used by the accumulator/index path.
    localparam int unsigned DIV_N     = 8;
    localparam int unsigned DIV_M     = 4;
    localparam int unsigned DIV_TAG_W = $clog2(`max_num_K) + 1;

    // The partial remainder needs one bit more than the divisor so that the
    // shifted value can be compared without overflow.
    function automatic int unsigned prem_width(input int unsigned m);
        return m + 1;
    endfunction

    localparam int unsigned DIV_PW = prem_width(DIV_M);

    // Contents of one pipeline stage at the default geometry.
    typedef struct packed {
        logic                 valid;
        logic [DIV_PW-1:0]    prem;
        logic [DIV_N-1:0]     dvd_rem;
        logic [DIV_M-1:0]     dvs;
        logic [DIV_N-1:0]     quo;
        logic                 div0;
        logic [DIV_N-1:0]     dvd_orig;
        logic [DIV_TAG_W-1:0] tag;
    } stage_t;

endpackage

// File: rtl/divider_pipe_stage.sv
// One restoring-division step: shift in a dividend bit, conditionally
// subtract the divisor, shift in a quotient bit, then register with hold.
module divider_pipe_stage
    import divider_pkg::*;
#(
    parameter int unsigned N     = DIV_N,
    parameter int unsigned M     = DIV_M,
    parameter int unsigned TAG_W = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [M:0]       prem_i,
    input  logic [N-1:0]     dvd_rem_i,
    input  logic [M-1:0]     dvs_i,
    input  logic [N-1:0]     quo_i,
    input  logic             div0_i,
    input  logic [N-1:0]     dvd_orig_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [M:0]       prem_o,
    output logic [N-1:0]     dvd_rem_o,
    output logic [M-1:0]     dvs_o,
    output logic [N-1:0]     quo_o,
    output logic             div0_o,
    output logic [N-1:0]     dvd_orig_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int unsigned PW = prem_width(M);

    typedef struct packed {
        logic             valid;
        logic [PW-1:0]    prem;
        logic [N-1:0]     dvd_rem;
        logic [M-1:0]     dvs;
        logic [N-1:0]     quo;
        logic             div0;
        logic [N-1:0]     dvd_orig;
        logic [TAG_W-1:0] tag;
    } rec_t;

    rec_t          stage_d, stage_q;
    logic [PW-1:0] shifted;
    logic [PW-1:0] dvs_ext;
    logic [PW-1:0] diff;
    logic          q_bit;
    logic          unused_prem_msb;

    // The incoming partial remainder is always below the divisor, so its
    // top bit is zero and drops out of the shift.
    assign unused_prem_msb = prem_i[M];

    // Compare/subtract/shift step; bubbles only clear valid so the data
    // fields (and hence the block outputs) stay quiet.
    always_comb begin
        stage_d       = stage_q;
        shifted       = {prem_i[M-1:0], dvd_rem_i[N-1]};
        dvs_ext       = {1'b0, dvs_i};
        q_bit         = (shifted >= dvs_ext);
        diff          = shifted - dvs_ext;
        stage_d.valid = valid_i;
        if (valid_i) begin
            stage_d.prem     = q_bit ? diff : shifted;
            stage_d.dvd_rem  = {dvd_rem_i[N-2:0], 1'b0};
            stage_d.dvs      = dvs_i;
            stage_d.quo      = {quo_i[N-2:0], q_bit};
            stage_d.div0     = div0_i;
            stage_d.dvd_orig = dvd_orig_i;
            stage_d.tag      = tag_i;
        end
    end

    // Stage register; holds everything while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= stage_d;
        end
    end

    assign valid_o    = stage_q.valid;
    assign prem_o     = stage_q.prem;
    assign dvd_rem_o  = stage_q.dvd_rem;
    assign dvs_o      = stage_q.dvs;
    assign quo_o      = stage_q.quo;
    assign div0_o     = stage_q.div0;
    assign dvd_orig_o = stage_q.dvd_orig;
    assign tag_o      = stage_q.tag;

endmodule

// File: rtl/divider_pipe.sv
// Fully pipelined unsigned restoring divider, one quotient bit per stage,
// with valid/ready backpressure, divide-by-zero override and tag pass-through.
module divider_pipe
    import divider_pkg::*;
#(
    parameter int unsigned N     = DIV_N,
    parameter int unsigned M     = DIV_M,
    parameter int unsigned TAG_W = DIV_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     dividend,
    input  logic [M-1:0]     divisor,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     quotient,
    output logic [M-1:0]     remainder,
    output logic             div_by_zero,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    // Index 0 is the entry point; index i+1 is the register of stage i.
    logic             valid_w    [0:N];
    logic [M:0]       prem_w     [0:N];
    logic [N-1:0]     dvd_rem_w  [0:N];
    logic [M-1:0]     dvs_w      [0:N];
    logic [N-1:0]     quo_w      [0:N];
    logic             div0_w     [0:N];
    logic [N-1:0]     dvd_orig_w [0:N];
    logic [TAG_W-1:0] tag_w      [0:N];

    logic stall;
    logic busy_any;
    logic unused_tail;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign valid_w[0]    = in_valid;
    assign prem_w[0]     = '0;
    assign dvd_rem_w[0]  = dividend;
    assign dvs_w[0]      = divisor;
    assign quo_w[0]      = '0;
    assign div0_w[0]     = (divisor == '0);
    assign dvd_orig_w[0] = dividend;
    assign tag_w[0]      = tag_in;

    for (genvar i = 0; i < N; i++) begin : g_stage
        divider_pipe_stage #(
            .N     (N),
            .M     (M),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (!stall),
            .valid_i    (valid_w[i]),
            .prem_i     (prem_w[i]),
            .dvd_rem_i  (dvd_rem_w[i]),
            .dvs_i      (dvs_w[i]),
            .quo_i      (quo_w[i]),
            .div0_i     (div0_w[i]),
            .dvd_orig_i (dvd_orig_w[i]),
            .tag_i      (tag_w[i]),
            .valid_o    (valid_w[i+1]),
            .prem_o     (prem_w[i+1]),
            .dvd_rem_o  (dvd_rem_w[i+1]),
            .dvs_o      (dvs_w[i+1]),
            .quo_o      (quo_w[i+1]),
            .div0_o     (div0_w[i+1]),
            .dvd_orig_o (dvd_orig_w[i+1]),
            .tag_o      (tag_w[i+1])
        );
    end

    // Busy whenever any stage, including the output stage, holds an operation.
    always_comb begin
        busy_any = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            busy_any = busy_any | valid_w[i];
        end
    end

    // Fully consumed dividend bits and the divisor are not needed past the
    // last stage; only the low dividend bits matter for the div0 remainder.
    assign unused_tail = ^{prem_w[N][M], dvd_rem_w[N], dvs_w[N], dvd_orig_w[N]};

    assign busy        = busy_any;
    assign out_valid   = valid_w[N];
    assign div_by_zero = div0_w[N];
    assign quotient    = div0_w[N] ? '1 : quo_w[N];
    assign remainder   = div0_w[N] ? dvd_orig_w[N][M-1:0] : prem_w[N][M-1:0];
    assign tag_out     = tag_w[N];

endmodule

// File: tb/tb_divider_pipe.sv
// Directed bench for divider_pipe (N=8, M=4, TAG_W=4) plus a short scoreboarded soak.
module tb_divider_pipe;

    localparam int unsigned N     = 8;
    localparam int unsigned M     = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NSOAK = 400;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     dividend;
    logic [M-1:0]     divisor;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     quotient;
    logic [M-1:0]     remainder;
    logic             div_by_zero;
    logic [TAG_W-1:0] tag_out;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divider_pipe #(
        .N     (N),
        .M     (M),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .tag_in      (tag_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .tag_out     (tag_out),
        .busy        (busy)
    );

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [M-1:0] b, input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tag_in   = t;
    endtask

    task automatic expect_res(input string nm, input logic [N-1:0] q, input logic [M-1:0] r,
                              input logic z, input logic [TAG_W-1:0] t);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_q"}, quotient, q);
        chk({nm, "_r"}, remainder, r);
        chk({nm, "_dbz"}, div_by_zero, z);
        chk({nm, "_tag"}, tag_out, t);
    endtask

    function automatic logic [N+M+TAG_W:0] model(input logic [N-1:0] a, input logic [M-1:0] b,
                                                 input logic [TAG_W-1:0] t);
        logic [N-1:0] q;
        logic [N-1:0] r;
        if (b == 0) begin
            q = '1;
            r = a;
            return {q, r[M-1:0], 1'b1, t};
        end
        q = a / N'(b);
        r = a % N'(b);
        return {q, r[M-1:0], 1'b0, t};
    endfunction

    logic [7:0] a4 [8] = '{8'd200, 8'd77, 8'd0, 8'd255, 8'd128, 8'd50, 8'd9, 8'd99};
    logic [3:0] b4 [8] = '{4'd9,   4'd5,  4'd3, 4'd1,   4'd15,  4'd0,  4'd10, 4'd11};
    logic [7:0] q4 [8] = '{8'd22,  8'd15, 8'd0, 8'd255, 8'd8,   8'd255, 8'd0, 8'd9};
    logic [3:0] r4 [8] = '{4'd2,   4'd2,  4'd0, 4'd0,   4'd8,   4'd2,  4'd9,  4'd0};
    logic       z4 [8] = '{1'b0,   1'b0,  1'b0, 1'b0,   1'b0,   1'b1,  1'b0,  1'b0};

    logic [N+M+TAG_W:0] sb [$];
    logic [N+M+TAG_W:0] exp_v;
    logic               acc;
    int unsigned        sent;
    int unsigned        got;
    int unsigned        cyc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tag_in    = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_tag", tag_out, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // 100 / 7 with exact latency
        drive(8'd100, 4'd7, 4'd3);
        tick();
        in_valid = 1'b0;
        chk("t1_busy", busy, 1);
        repeat (N - 2) tick();
        chk("t1_not_early", out_valid, 0);
        tick();
        expect_res("t1", 8'd14, 4'd2, 1'b0, 4'd3);
        tick();
        chk("t1_drained", out_valid, 0);
        chk("t1_idle", busy, 0);

        // Back-to-back: exact division and dividend < divisor
        drive(8'd255, 4'd15, 4'd1);
        tick();
        drive(8'd3, 4'd9, 4'd2);
        tick();
        in_valid = 1'b0;
        repeat (N - 2) tick();
        expect_res("t2a", 8'd17, 4'd0, 1'b0, 4'd1);
        tick();
        expect_res("t2b", 8'd0, 4'd3, 1'b0, 4'd2);
        tick();
        chk("t2_drained", out_valid, 0);

        // Divide by zero
        drive(8'd13, 4'd0, 4'd5);
        tick();
        in_valid = 1'b0;
        repeat (N / 2) tick();
        chk("t3_busy", busy, 1);
        chk("t3_not_early", out_valid, 0);
        repeat (N / 2 - 1) tick();
        expect_res("t3", 8'd255, 4'd13, 1'b1, 4'd5);
        tick();
        chk("t3_idle", busy, 0);

        // Eight back-to-back operations, 3-cycle stall, an offer held during the stall
        for (int k = 0; k < 8; k++) begin
            drive(a4[k], b4[k], TAG_W'(k));
            tick();
        end
        in_valid = 1'b0;
        expect_res("t4_op0", q4[0], r4[0], z4[0], 4'd0);
        out_ready = 1'b0;
        drive(8'd1, 4'd1, 4'd15);
        #1;
        chk("t4_stall_in_ready", in_ready, 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            expect_res($sformatf("t4_hold%0d", s), q4[0], r4[0], z4[0], 4'd0);
            chk($sformatf("t4_hold%0d_in_ready", s), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            expect_res($sformatf("t4_op%0d", k), q4[k], r4[k], z4[k], TAG_W'(k));
            tick();
        end
        expect_res("t4_held_offer", 8'd1, 4'd0, 1'b0, 4'd15);
        tick();
        chk("t4_drained", out_valid, 0);
        chk("t4_idle", busy, 0);

        // Reset mid-flight discards everything
        drive(8'd20, 4'd3, 4'd1);
        tick();
        drive(8'd40, 4'd6, 4'd2);
        tick();
        drive(8'd60, 4'd7, 4'd3);
        tick();
        drive(8'd80, 4'd9, 4'd4);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t5_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < int'(N) + 2; c++) begin
            tick();
            chk($sformatf("t5_no_stale%0d", c), out_valid, 0);
        end
        drive(8'd100, 4'd7, 4'd9);
        tick();
        in_valid = 1'b0;
        repeat (N - 1) tick();
        expect_res("t5_after", 8'd14, 4'd2, 1'b0, 4'd9);
        tick();

        // Random soak with random valid/ready against a reference model
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < NSOAK && cyc < 20000) begin
            if (!in_valid && sent < NSOAK && $urandom_range(3) != 0) begin
                drive(N'($urandom), M'($urandom), TAG_W'(sent));
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("soak_unexpected_result", out_valid, 0);
                end else begin
                    exp_v = sb.pop_front();
                    chk($sformatf("soak_result%0d", got),
                        {quotient, remainder, div_by_zero, tag_out}, exp_v);
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                sb.push_back(model(dividend, divisor, tag_in));
                sent++;
            end
            tick();
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        chk("soak_completed", got, NSOAK);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
